// File: rtl/nvdla_cdp_intp_pkg.sv
// ============================================================================
// nvdla_cdp_intp_pkg : shared encodings, derived widths and bounds for CDP intp
// Revision: 1.0
// ============================================================================
`default_nettype none

package nvdla_cdp_intp_pkg;

  localparam int DEF_LANES   = 4;
  localparam int DEF_IN_W    = 39;
  localparam int DEF_FRAC_W  = 17;
  localparam int DEF_BASE_W  = 17;
  localparam int DEF_OUT_W   = 16;
  localparam int DEF_SHIFT_W = 6;

  typedef enum logic {
    RND_FLOOR     = 1'b0,
    RND_HALF_AWAY = 1'b1
  } rnd_mode_e;

  function automatic int sub_w(input int in_w);
    return in_w + 1;
  endfunction

  function automatic int mul_w(input int in_w, input int frac_w);
    return in_w + frac_w + 1;
  endfunction

  // Wide enough for the product left-shifted by the most negative shift code.
  function automatic int sh_w(input int in_w, input int frac_w, input int shift_w);
    return mul_w(in_w, frac_w) + (1 << (shift_w - 1)) + 1;
  endfunction

  localparam int SUB_W = sub_w(DEF_IN_W);
  localparam int MUL_W = mul_w(DEF_IN_W, DEF_FRAC_W);
  localparam int SH_W  = sh_w(DEF_IN_W, DEF_FRAC_W, DEF_SHIFT_W);

  localparam logic [DEF_OUT_W-1:0] OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic [DEF_OUT_W-1:0] OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/nvdla_cdp_intp_lane.sv
// ============================================================================
// nvdla_cdp_intp_lane : one lane of subtract / multiply / shift-round-saturate
// Revision: 1.0
// ============================================================================
`default_nettype none

module nvdla_cdp_intp_lane
  import nvdla_cdp_intp_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int BASE_W  = DEF_BASE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               ld0,
  input  logic               ld1,
  input  logic               ld2,
  input  logic [IN_W-1:0]    x0,
  input  logic [IN_W-1:0]    x1,
  input  logic [BASE_W-1:0]  base,
  input  logic [FRAC_W-1:0]  s0_frac,
  input  logic [SHIFT_W-1:0] s1_shift,
  input  logic               s1_rnd,
  input  logic               s1_bypass,
  output logic [OUT_W-1:0]   out_pd,
  output logic               out_sat
);

  localparam int SUBW = sub_w(IN_W);
  localparam int MULW = mul_w(IN_W, FRAC_W);
  localparam int SHW  = sh_w(IN_W, FRAC_W, SHIFT_W);
  localparam int SUMW = SHW + 1;

  localparam logic signed [SUMW-1:0] SAT_MAX = {{(SUMW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUMW-1:0] SAT_MIN = {{(SUMW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [SUBW-1:0]   sub_q,   sub_d;
  logic [BASE_W-1:0] base0_q, base0_d;
  logic [MULW-1:0]   mul_q,   mul_d;
  logic [BASE_W-1:0] base1_q, base1_d;
  logic [OUT_W-1:0]  out_q,   out_d;
  logic              sat_q,   sat_d;

  logic                   neg_sh;
  logic [SHIFT_W-1:0]     shamt;
  logic signed [SHW-1:0]  mul_ext;
  logic signed [SHW-1:0]  shl;
  logic signed [SHW-1:0]  shr;
  logic signed [SHW-1:0]  shifted;
  logic [SHW-1:0]         one;
  logic [SHW-1:0]         mask;
  logic [SHW-1:0]         rem;
  logic [SHW-1:0]         half;
  logic                   inc;
  logic signed [SUMW-1:0] sum;
  logic                   sat_hi;
  logic                   sat_lo;

  always_comb begin
    sub_d   = ld0 ? ({x1[IN_W-1], x1} - {x0[IN_W-1], x0}) : sub_q;
    base0_d = ld0 ? base : base0_q;
    mul_d   = ld1 ? (MULW'($signed(sub_q)) * MULW'($signed(s0_frac))) : mul_q;
    base1_d = ld1 ? base0_q : base1_q;
  end

  // Negative shift codes select a left shift; the most negative code has no
  // positive counterpart, so the magnitude is kept as an unsigned value.
  always_comb begin
    neg_sh  = s1_shift[SHIFT_W-1];
    shamt   = neg_sh ? (~s1_shift + SHIFT_W'(1)) : s1_shift;
    mul_ext = SHW'($signed(mul_q));
    shl     = mul_ext <<< shamt;
    shr     = mul_ext >>> shamt;
    one     = SHW'(1);
    mask    = (one << shamt) - one;
    rem     = mul_ext & mask;
    half    = one << (shamt - SHIFT_W'(1));
    // Ties round up only for non-negative products: half away from zero on floor.
    inc     = (s1_rnd == RND_HALF_AWAY) && !neg_sh && (shamt != '0) &&
              ((rem > half) || ((rem == half) && !mul_q[MULW-1]));
    if (s1_bypass) begin
      shifted = '0;
    end else if (neg_sh) begin
      shifted = shl;
    end else begin
      shifted = shr + {{(SHW-1){1'b0}}, inc};
    end
    sum    = SUMW'(shifted) + SUMW'($signed(base1_q));
    sat_hi = sum > SAT_MAX;
    sat_lo = sum < SAT_MIN;
  end

  always_comb begin
    out_d = out_q;
    sat_d = sat_q;
    if (ld2) begin
      sat_d = sat_hi | sat_lo;
      if (sat_hi) begin
        out_d = SAT_MAX[OUT_W-1:0];
      end else if (sat_lo) begin
        out_d = SAT_MIN[OUT_W-1:0];
      end else begin
        out_d = sum[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sub_q   <= '0;
      base0_q <= '0;
      mul_q   <= '0;
      base1_q <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      base0_q <= base0_d;
      mul_q   <= mul_d;
      base1_q <= base1_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  assign out_pd  = out_q;
  assign out_sat = sat_q;

endmodule

`default_nettype wire

// File: rtl/nvdla_cdp_dp_intp_mlane.sv
// ============================================================================
// nvdla_cdp_dp_intp_mlane : multi-lane CDP interpolation, 3-stage valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module nvdla_cdp_dp_intp_mlane
  import nvdla_cdp_intp_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int BASE_W  = DEF_BASE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [LANES*IN_W-1:0]     in_x0_pd,
  input  logic [LANES*IN_W-1:0]     in_x1_pd,
  input  logic [LANES*BASE_W-1:0]   in_base_pd,
  input  logic [FRAC_W-1:0]         in_frac,
  input  logic [SHIFT_W-1:0]        in_shift,
  input  logic                      in_rnd,
  input  logic                      in_bypass,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [LANES*OUT_W-1:0]    out_pd,
  output logic [LANES-1:0]          out_sat,
  output logic [31:0]               sat_cnt,
  input  logic                      sat_cnt_clr
);

  localparam int POP_W = $clog2(LANES + 1);

  logic vld0_q, vld0_d, vld1_q, vld1_d, vld2_q, vld2_d;
  logic rdy0, rdy1, rdy2;
  logic ld0, ld1, ld2;

  logic [FRAC_W-1:0]  frac0_q,  frac0_d;
  logic [SHIFT_W-1:0] shift0_q, shift0_d, shift1_q, shift1_d;
  logic               rnd0_q,   rnd0_d,   rnd1_q,   rnd1_d;
  logic               byp0_q,   byp0_d,   byp1_q,   byp1_d;

  logic [31:0]        sat_cnt_q, sat_cnt_d;
  logic [POP_W-1:0]   sat_pop;
  logic [32:0]        cnt_sum;
  logic               fire;

  always_comb begin
    rdy2   = ~vld2_q | out_rdy;
    rdy1   = ~vld1_q | rdy2;
    rdy0   = ~vld0_q | rdy1;
    ld0    = in_vld & rdy0;
    ld1    = vld0_q & rdy1;
    ld2    = vld1_q & rdy2;
    vld0_d = ld0 ? 1'b1 : (rdy0 ? 1'b0 : vld0_q);
    vld1_d = ld1 ? 1'b1 : (rdy1 ? 1'b0 : vld1_q);
    vld2_d = ld2 ? 1'b1 : (rdy2 ? 1'b0 : vld2_q);
  end

  // Shared per-beat controls travel alongside the lane data.
  always_comb begin
    frac0_d  = ld0 ? in_frac   : frac0_q;
    shift0_d = ld0 ? in_shift  : shift0_q;
    rnd0_d   = ld0 ? in_rnd    : rnd0_q;
    byp0_d   = ld0 ? in_bypass : byp0_q;
    shift1_d = ld1 ? shift0_q  : shift1_q;
    rnd1_d   = ld1 ? rnd0_q    : rnd1_q;
    byp1_d   = ld1 ? byp0_q    : byp1_q;
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      nvdla_cdp_intp_lane #(
        .IN_W    (IN_W),
        .FRAC_W  (FRAC_W),
        .BASE_W  (BASE_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
      ) u_lane (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .ld0             (ld0),
        .ld1             (ld1),
        .ld2             (ld2),
        .x0              (in_x0_pd[l*IN_W +: IN_W]),
        .x1              (in_x1_pd[l*IN_W +: IN_W]),
        .base            (in_base_pd[l*BASE_W +: BASE_W]),
        .s0_frac         (frac0_q),
        .s1_shift        (shift1_q),
        .s1_rnd          (rnd1_q),
        .s1_bypass       (byp1_q),
        .out_pd          (out_pd[l*OUT_W +: OUT_W]),
        .out_sat         (out_sat[l])
      );
    end
  endgenerate

  always_comb begin
    fire    = vld2_q & out_rdy;
    sat_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      sat_pop = sat_pop + POP_W'(out_sat[l]);
    end
    cnt_sum = {1'b0, sat_cnt_q} + 33'(sat_pop);
    if (sat_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (fire) begin
      sat_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      vld2_q    <= 1'b0;
      frac0_q   <= '0;
      shift0_q  <= '0;
      rnd0_q    <= 1'b0;
      byp0_q    <= 1'b0;
      shift1_q  <= '0;
      rnd1_q    <= 1'b0;
      byp1_q    <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      vld0_q    <= vld0_d;
      vld1_q    <= vld1_d;
      vld2_q    <= vld2_d;
      frac0_q   <= frac0_d;
      shift0_q  <= shift0_d;
      rnd0_q    <= rnd0_d;
      byp0_q    <= byp0_d;
      shift1_q  <= shift1_d;
      rnd1_q    <= rnd1_d;
      byp1_q    <= byp1_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign in_rdy  = rdy0;
  assign out_vld = vld2_q;
  assign sat_cnt = sat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_nvdla_cdp_dp_intp_mlane.sv
// ============================================================================
// tb_nvdla_cdp_dp_intp_mlane : directed self-checking bench, 4 lanes default
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nvdla_cdp_dp_intp_mlane;

  logic               nvdla_core_clk;
  logic               nvdla_core_rstn;
  logic               in_vld;
  logic               in_rdy;
  logic [155:0]       in_x0_pd;
  logic [155:0]       in_x1_pd;
  logic [67:0]        in_base_pd;
  logic [16:0]        in_frac;
  logic [5:0]         in_shift;
  logic               in_rnd;
  logic               in_bypass;
  logic               out_vld;
  logic               out_rdy;
  logic [63:0]        out_pd;
  logic [3:0]         out_sat;
  logic [31:0]        sat_cnt;
  logic               sat_cnt_clr;

  logic [38:0] x0 [4];
  logic [38:0] x1 [4];
  logic [16:0] base [4];

  int compared   = 0;
  int mismatched = 0;

  assign in_x0_pd   = {x0[3], x0[2], x0[1], x0[0]};
  assign in_x1_pd   = {x1[3], x1[2], x1[1], x1[0]};
  assign in_base_pd = {base[3], base[2], base[1], base[0]};

  nvdla_cdp_dp_intp_mlane dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .in_vld          (in_vld),
    .in_rdy          (in_rdy),
    .in_x0_pd        (in_x0_pd),
    .in_x1_pd        (in_x1_pd),
    .in_base_pd      (in_base_pd),
    .in_frac         (in_frac),
    .in_shift        (in_shift),
    .in_rnd          (in_rnd),
    .in_bypass       (in_bypass),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .out_pd          (out_pd),
    .out_sat         (out_sat),
    .sat_cnt         (sat_cnt),
    .sat_cnt_clr     (sat_cnt_clr)
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input int a0, input int a1, input int b);
    for (int l = 0; l < 4; l++) begin
      x0[l]   = 39'(a0);
      x1[l]   = 39'(a1);
      base[l] = 17'(b);
    end
  endtask

  // Launch one beat on an idle front end and check its result three cycles later.
  task automatic beat(input string tag, input logic [63:0] exp_pd, input logic [3:0] exp_sat);
    in_vld = 1'b1;
    #1;
    chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
    @(negedge nvdla_core_clk);
    in_vld = 1'b0;
    @(negedge nvdla_core_clk);
    chk({tag, "_early"}, 64'(out_vld), 64'd0);
    @(negedge nvdla_core_clk);
    chk({tag, "_vld"}, 64'(out_vld), 64'd1);
    chk({tag, "_pd"}, out_pd, exp_pd);
    chk({tag, "_sat"}, 64'(out_sat), 64'(exp_sat));
  endtask

  function automatic logic [15:0] bp_exp(input int i, input int l);
    return 16'(100 * (i + 1) + 7 * l + 3 * i - 50);
  endfunction

  task automatic set_sat_beat();
    set_lanes(0, 0, 0);
    x1[0] = 39'(20000);
    x1[1] = 39'(100);
    x1[2] = 39'(-20000);
    x1[3] = 39'(100);
    in_frac  = 17'd2;
    in_shift = 6'd0;
    in_rnd   = 1'b1;
  endtask

  localparam logic [63:0] SAT_BEAT_PD = {16'h00C8, 16'h8000, 16'h00C8, 16'h7FFF};

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int recv;
    bit held_valid;
    bit saw_stall;
    logic [63:0] held_pd;
    logic [63:0] exp_bp;

    nvdla_core_rstn = 1'b0;
    in_vld      = 1'b0;
    out_rdy     = 1'b1;
    in_frac     = '0;
    in_shift    = '0;
    in_rnd      = 1'b1;
    in_bypass   = 1'b0;
    sat_cnt_clr = 1'b0;
    set_lanes(0, 0, 0);

    repeat (2) @(negedge nvdla_core_clk);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_pd", out_pd, 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    nvdla_core_rstn = 1'b1;
    @(negedge nvdla_core_clk);

    // Basic: 200 * 0.25 + 100
    in_frac = 17'h04000; in_shift = 6'd16; in_rnd = 1'b1;
    set_lanes(100, 300, 100);
    beat("basic", {4{16'd150}}, 4'h0);

    // Positive tie 1.5 and negative -1.25
    set_lanes(0, 3, 10); in_frac = 17'h08000;
    beat("rnd_pos_tie", {4{16'd12}}, 4'h0);
    in_rnd = 1'b0;
    beat("floor_pos_tie", {4{16'd11}}, 4'h0);
    set_lanes(0, -5, 10); in_frac = 17'h04000; in_rnd = 1'b1;
    beat("rnd_neg", {4{16'd9}}, 4'h0);
    in_rnd = 1'b0;
    beat("floor_neg", {4{16'd8}}, 4'h0);

    // -1 >> 31: floor -1, rounds to 0
    set_lanes(1, 0, 5); in_frac = 17'd1; in_shift = 6'd31; in_rnd = 1'b1;
    beat("rnd_shr31", {4{16'd5}}, 4'h0);
    in_rnd = 1'b0;
    beat("floor_shr31", {4{16'd4}}, 4'h0);

    in_rnd = 1'b1;
    set_lanes(0, 1000, 0); in_frac = 17'd1; in_shift = 6'h3E;
    beat("shl2", {4{16'd4000}}, 4'h0);
    set_lanes(0, 20000, 0); in_frac = 17'd2; in_shift = 6'd0;
    beat("sat_hi", {4{16'h7FFF}}, 4'hF);
    set_lanes(0, -20000, 0);
    beat("sat_lo", {4{16'h8000}}, 4'hF);

    // Most negative shift code: left shift by 32
    set_lanes(0, 0, 0);
    x1[0] = 39'(1); x1[1] = 39'(-1);
    in_frac = 17'd1; in_shift = 6'h20;
    beat("shl32", {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 4'b0011);

    in_bypass = 1'b1;
    set_lanes(5, 77777, 0);
    base[0] = 17'(-40000); base[1] = 17'(1234); base[2] = 17'(40000); base[3] = 17'(-5);
    beat("bypass", {16'hFFFB, 16'h7FFF, 16'd1234, 16'h8000}, 4'b0101);
    in_bypass = 1'b0;

    @(negedge nvdla_core_clk);
    chk("drain_vld", 64'(out_vld), 64'd0);

    // Backpressure: downstream stalls cycles 3..8
    sent = 0; recv = 0; held_valid = 1'b0; saw_stall = 1'b0; held_pd = '0;
    in_frac = 17'h04000; in_shift = 6'd14; in_rnd = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge nvdla_core_clk);
      out_rdy = !(c >= 3 && c <= 8);
      in_vld  = (sent < 6);
      for (int l = 0; l < 4; l++) begin
        x0[l]   = '0;
        x1[l]   = 39'(100 * (sent + 1) + 7 * l);
        base[l] = 17'(3 * sent - 50);
      end
      #1;
      if (!in_rdy) saw_stall = 1'b1;
      if (c == 2) chk("bp_rdy_c2", 64'(in_rdy), 64'd1);
      if (c == 3) chk("bp_rdy_c3", 64'(in_rdy), 64'd0);
      if (held_valid) begin
        chk("bp_hold_vld", 64'(out_vld), 64'd1);
        chk("bp_hold_pd", out_pd, held_pd);
      end
      held_valid = 1'b0;
      if (out_vld) begin
        if (out_rdy) begin
          exp_bp = {bp_exp(recv, 3), bp_exp(recv, 2), bp_exp(recv, 1), bp_exp(recv, 0)};
          chk("bp_data", out_pd, exp_bp);
          recv++;
        end else begin
          held_pd    = out_pd;
          held_valid = 1'b1;
        end
      end
      if (in_vld && in_rdy) sent++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    chk("bp_recv", 64'(recv), 64'd6);
    chk("bp_stall_seen", 64'(saw_stall), 64'd1);

    // Saturation counter
    @(negedge nvdla_core_clk);
    sat_cnt_clr = 1'b1;
    @(negedge nvdla_core_clk);
    sat_cnt_clr = 1'b0;
    chk("cnt_clr0", 64'(sat_cnt), 64'd0);
    set_sat_beat();
    beat("cnt_a", SAT_BEAT_PD, 4'b0101);
    beat("cnt_b", SAT_BEAT_PD, 4'b0101);
    chk("cnt_after_a", 64'(sat_cnt), 64'd2);
    beat("cnt_c", SAT_BEAT_PD, 4'b0101);
    chk("cnt_after_b", 64'(sat_cnt), 64'd4);
    @(negedge nvdla_core_clk);
    chk("cnt_after_c", 64'(sat_cnt), 64'd6);
    beat("cnt_d", SAT_BEAT_PD, 4'b0101);
    sat_cnt_clr = 1'b1;
    @(negedge nvdla_core_clk);
    sat_cnt_clr = 1'b0;
    chk("cnt_clr_prio", 64'(sat_cnt), 64'd0);

    beat("cnt_e", SAT_BEAT_PD, 4'b0101);
    force dut.sat_cnt_q = 32'hFFFF_FFFE;
    #1;
    chk("cnt_near_max", 64'(dut.sat_cnt_d), 64'hFFFF_FFFF);
    force dut.sat_cnt_q = 32'hFFFF_FFFF;
    #1;
    chk("cnt_at_max", 64'(dut.sat_cnt_d), 64'hFFFF_FFFF);
    sat_cnt_clr = 1'b1;
    release dut.sat_cnt_q;
    @(negedge nvdla_core_clk);
    sat_cnt_clr = 1'b0;
    chk("cnt_clr_after_max", 64'(sat_cnt), 64'd0);

    // Reset with two beats in flight
    beat("rst_pre", SAT_BEAT_PD, 4'b0101);
    in_vld = 1'b1;
    @(negedge nvdla_core_clk);
    in_frac = 17'h04000; in_shift = 6'd16; in_rnd = 1'b1;
    set_lanes(100, 300, 100);
    @(negedge nvdla_core_clk);
    in_vld = 1'b0;
    @(negedge nvdla_core_clk);
    chk("rst_mid_cnt_pre", 64'(sat_cnt), 64'd2);
    chk("rst_mid_vld_pre", 64'(out_vld), 64'd1);
    nvdla_core_rstn = 1'b0;
    #1;
    chk("rst_mid_vld", 64'(out_vld), 64'd0);
    chk("rst_mid_pd", out_pd, 64'd0);
    chk("rst_mid_sat", 64'(out_sat), 64'd0);
    chk("rst_mid_cnt", 64'(sat_cnt), 64'd0);
    repeat (2) @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge nvdla_core_clk);
      chk("rst_no_ghost", 64'(out_vld), 64'd0);
    end
    beat("post_rst", {4{16'd150}}, 4'h0);
    @(negedge nvdla_core_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nvdla_cdp_dp_intp_mlane.md
Name: nvdla_cdp_dp_intp_mlane

Overview:
Multi-lane, parametrised successor of the CDP linear-interpolation unit. Each lane computes Xo = base + round((X1 - X0) * frac, shift) and saturates the result to a signed OUT_W value. The block sits between the CDP LUT lookup stage and the CDP multiply stage. Compared with the single-lane unit it adds:
- LANES parallel lanes with a shared frac/shift.
- Selectable rounding mode.
- Bypass mode.
- Per-lane saturation flags and a saturation event counter.

Parameters:
LANES, 4, number of parallel interpolation lanes
IN_W, 39, signed width of X0/X1 per lane
FRAC_W, 17, signed width of shared frac/scale
BASE_W, 17, signed width of base per lane
OUT_W, 16, signed width of saturated output per lane
SHIFT_W, 6, signed two's-complement shift width; positive = right shift, negative = left shift

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rstn  in  1  reset, asynchronous, active-low
in_vld  in  1  input beat valid
in_rdy  out  1  input beat accepted when in_vld & in_rdy
in_x0_pd  in  LANES*IN_W  X0 per lane, lane0 in LSBs
in_x1_pd  in  LANES*IN_W  X1 per lane
in_base_pd  in  LANES*BASE_W  base term per lane
in_frac  in  FRAC_W  shared signed fraction
in_shift  in  SHIFT_W  shared signed shift
in_rnd  in  1  1 = round-half-away-from-zero, 0 = truncate (floor)
in_bypass  in  1  1 = out = sat(base); X0/X1/frac ignored
out_vld  out  1  output beat valid
out_rdy  in  1  downstream ready
out_pd  out  LANES*OUT_W  saturated result per lane
out_sat  out  LANES  per-lane saturation flag for this beat
sat_cnt  out  32  saturating count of saturated lane-results delivered
sat_cnt_clr  in  1  synchronous clear of sat_cnt

Behaviour:
- Reset: all stage valids = 0; all data registers = 0; out_vld = 0; out_pd = 0; out_sat = 0; sat_cnt = 0.
- Pipeline: 3 registered stages (S0 subtract, S1 multiply, S2 shift/round/add/saturate).
  - Latency: in handshake to out_vld is 3 cycles. Throughput: 1 beat per cycle.
  - Per stage n: rdy_n = ~vld_n | rdy_{n+1}; rdy_3 = out_rdy; in_rdy = rdy_0.
  - vld_n <= load_{n-1} ? 1 : (rdy_n ? 0 : vld_n).
  - Data loads only on load_{n-1}. A stage may never set valid without a handshake.
  - Stalled stages hold data; out_pd and out_sat stay stable while out_vld & ~out_rdy.
  - No skid buffer: at most 3 beats in flight. Beat order is preserved and no beat is dropped.
- S0:
  - sub = sext(x1) - sext(x0), width IN_W+1.
  - Register base, frac, shift, rnd and bypass alongside.
- S1: mul = sub * frac, signed, width IN_W+FRAC_W+1.
- S2, shift handling:
  - Left shift when shift < 0, by |shift|; the internal width must hold the full left-shifted product.
  - Arithmetic right shift when shift >= 0. Discarded bits form the remainder.
  - Shift = -2^(SHIFT_W-1) is legal; its magnitude is 2^(SHIFT_W-1).
- S2, rounding (right shift only):
  - rnd=1: add 1 if remainder > half. Add 1 on exactly half only when mul >= 0, giving ties away from zero.
  - rnd=0: floor.
  - Right shift beyond the product width yields 0 or -1 before rounding.
- S2, add and saturate:
  - sum = shifted + sext(base), computed with no overflow.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat[l] = 1 when clipping occurred.
- Bypass: shifted term forced to 0, so out = sat(base); latency is unchanged.
- sat_cnt:
  - On out_vld & out_rdy, add popcount(out_sat); saturate at 0xFFFFFFFF.
  - sat_cnt_clr has priority: the same-cycle increment is dropped and the next value is 0.
- Reset mid-operation: in-flight beats are discarded and no partial output is produced.
- Rnd and bypass changes take effect per beat, with no pipeline flush.

Decomposition:
- Package nvdla_cdp_intp_pkg holds:
  - rounding-mode encodings (RND_FLOOR = 0, RND_HALF_AWAY = 1);
  - derived widths SUB_W = IN_W+1, MUL_W = IN_W+FRAC_W+1, SH_W = MUL_W+2^(SHIFT_W-1)+1;
  - saturation bound constants.
- Sub-module nvdla_cdp_intp_lane: one lane's S0–S2 datapath with registers and shared load enables.
- The top module owns valid/ready control, out_sat assembly and sat_cnt.

Test Plan (LANES=4, IN_W=39, FRAC_W=17, BASE_W=17, OUT_W=16):
1. Basic: x0=100, x1=300, frac=0x4000, shift=16, base=100, rnd=1 -> out=150, sat=0, out_vld 3 cycles after accept.
2. Rounding:
   - x0=0, x1=3, frac=0x8000, shift=16, base=10 -> rnd=1 gives 12, rnd=0 gives 11.
   - x1=-5, frac=0x4000 -> rnd=1 gives 9, rnd=0 gives 8.
3. Shift/saturation:
   - shift=-2, sub=1000, frac=1, base=0 -> 4000.
   - sub=20000, frac=2, shift=0 -> 0x7FFF, sat=1.
   - sub=-20000 -> 0x8000, sat=1.
   - bypass=1, base=-40000 (out of range for 16 bits) -> 0x8000.
4. Backpressure: 6 back-to-back beats with out_rdy=0 for cycles 3–8 -> in_rdy falls once 3 beats are held; outputs stay stable; all 6 arrive in order with no loss.
5. sat_cnt: 3 accepted beats with lanes 0 and 2 saturating -> sat_cnt=6; sat_cnt_clr asserted with a 4th saturating beat -> sat_cnt=0; counter preloaded near max saturates at 0xFFFFFFFF.
6. Reset mid-stream: assert nvdla_core_rstn low with 2 beats in flight -> out_vld=0, sat_cnt=0, out_pd=0 immediately; after release, new beats produce correct results.
